bus_timer: RTL and testbench
============================

// Module: bus_timer
// PURPOSE
//  Bus responder peripheral on the dcpu data bus, selected by syscon like blkmem.
//  Provides a prescaled 16-bit down-counter with auto-reload and a level interrupt
//  into the CPU's i_int input. Four 16-bit registers, single-cycle registered ack.
// PARAMETERS
//  RST_RELOAD    16'h0000  reset value of RELOAD register
//  RST_PRESCALE  16'h0000  reset value of PRESCALE register (0 = tick every cycle)
// PORTS
//  i_clk     in   1   clock; all state changes on rising edge
//  i_reset   in   1   synchronous reset, active-high
//  i_addr    in   2   register index (CPU byte address bits [2:1])
//  i_dat     in   16  write data from CPU
//  o_dat     out  16  read data, valid while o_ack=1
//  i_we      in   1   1 = write, 0 = read
//  i_cyc     in   1   slave select from syscon (cycle active)
//  i_stb     in   2   byte strobes: [1]=bits 15:8, [0]=bits 7:0
//  o_ack     out  1   one-cycle acknowledge
//  o_int     out  1   interrupt request, level
// BEHAVIOUR
//  Registers (i_addr):
//   0 CTRL: [0] EN, [1] AUTO (reload), [2] IE, [3] PEND (read; write 1 clears), [15:4] read 0
//   1 RELOAD  2 COUNT (write loads counter; read = live value)  3 PRESCALE
//  Reset: all regs 0 except RELOAD=RST_RELOAD, PRESCALE=RST_PRESCALE;
//   prescale counter 0; o_ack=0, o_dat=0, o_int=0. Reset mid-cycle drops ack; no write lands.
//  Handshake: access accepted on edge where i_cyc=1 && o_ack=0.
//   - accept edge: write applied (only bytes with i_stb bit set); read data latched to o_dat.
//   - o_ack=1 for exactly the following cycle, then 0 even if i_cyc stays high.
//   - i_cyc held high through ack -> next accept one cycle after ack falls (2 cycles/access min).
//   - i_stb=00: acked, nothing written. Reads ignore i_stb (full word returned).
//   - i_cyc dropped during ack cycle: ack still completes, no side effects.
//  o_dat holds last read value when o_ack=0 (not required to be 0).
//  Prescaler: when EN=1, pcnt counts down; at pcnt==0 -> tick, pcnt<=PRESCALE.
//   Tick period = PRESCALE+1 cycles. EN=0 -> pcnt held at PRESCALE value loaded on enable.
//   Write of CTRL setting EN 0->1 loads pcnt<=PRESCALE (first tick after PRESCALE+1 cycles).
//  Counter on tick: COUNT!=0 -> COUNT-1. COUNT==0 -> PEND<=1; AUTO=1 -> COUNT<=RELOAD;
//   AUTO=0 -> EN<=0, COUNT stays 0. 16-bit unsigned, no underflow wrap to FFFF.
//  o_int = PEND & IE, registered-free combinational from flops (no glitch sources).
//  Simultaneous events:
//   - bus write to COUNT and tick same edge -> written value wins, no PEND from that tick.
//   - PEND write-1-clear and new expiry same edge -> PEND stays 1 (set wins).
//   - CTRL write clearing EN and tick same edge -> tick still processed this edge.
//   - read of COUNT on tick edge returns pre-tick value.
// TESTING
//  1 reset: assert i_reset 2 cycles -> o_ack=0, o_int=0, reads CTRL=0, COUNT=0, PRESCALE=RST_PRESCALE.
//  2 handshake: write RELOAD=16'h1234 with i_cyc held 4 cycles -> o_ack pulses exactly twice
//    (cycles 2,4); readback 16'h1234; write with stb=2'b01 data 16'hABCD -> RELOAD=16'h12CD.
//  3 one-shot: PRESCALE=0, COUNT=3, CTRL=0x5 -> PEND and o_int rise 4 cycles after write ack
//    edge, EN reads 0, COUNT holds 0.
//  4 auto-reload: PRESCALE=1, RELOAD=2, COUNT=2, CTRL=0x7 -> o_int period 6 cycles; write
//    CTRL=0xF clears PEND, o_int low next cycle, EN/AUTO/IE unchanged.
//  5 collisions: COUNT write on tick edge -> written value read back; PEND clear on expiry
//    edge -> PEND remains 1.
//  6 reset mid-access: i_reset on accept edge of write COUNT=16'h00FF -> no ack, COUNT=0.

Source files
------------

// File: rtl/bus_timer.sv
// Bus-mapped prescaled 16-bit down-counter with auto-reload and a level interrupt.
// Four 16-bit registers behind a cyc/ack handshake that acks one cycle after acceptance.
module bus_timer #(
  parameter logic [15:0] RST_RELOAD   = 16'h0000,
  parameter logic [15:0] RST_PRESCALE = 16'h0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [1:0]  i_addr,
  input  logic [15:0] i_dat,
  output logic [15:0] o_dat,
  input  logic        i_we,
  input  logic        i_cyc,
  input  logic [1:0]  i_stb,
  output logic        o_ack,
  output logic        o_int
);

  typedef enum logic [1:0] {
    REG_CTRL     = 2'd0,
    REG_RELOAD   = 2'd1,
    REG_COUNT    = 2'd2,
    REG_PRESCALE = 2'd3
  } reg_e;

  logic        en, auto_rl, ie, pend;
  logic [15:0] reload, count, prescale, pcnt;

  reg_e        sel;
  logic        accept, wr, ctrl_wr, count_wr, tick, expire;
  logic [15:0] ctrl_rd;

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] wdat,
                                        input logic [1:0] stb);
    return {stb[1] ? wdat[15:8] : old[15:8], stb[0] ? wdat[7:0] : old[7:0]};
  endfunction

  assign sel      = reg_e'(i_addr);
  assign accept   = i_cyc && !o_ack;
  assign wr       = accept && i_we && (i_stb != 2'b00);
  // CTRL only has live bits in the low byte, so an upper-byte-only write is a no-op.
  assign ctrl_wr  = wr && (sel == REG_CTRL) && i_stb[0];
  assign count_wr = wr && (sel == REG_COUNT);
  assign tick     = en && (pcnt == 16'd0);
  // A bus write to COUNT on the same edge overrides the tick, including its expiry.
  assign expire   = tick && (count == 16'd0) && !count_wr;
  assign ctrl_rd  = {12'h000, pend, ie, auto_rl, en};
  assign o_int    = pend & ie;

  // NOTE: every register here is state, so all assignments are non-blocking and every
  // flop is cleared by the synchronous reset -- there is no memory array to exempt.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      en       <= 1'b0;
      auto_rl  <= 1'b0;
      ie       <= 1'b0;
      pend     <= 1'b0;
      reload   <= RST_RELOAD;
      count    <= 16'd0;
      prescale <= RST_PRESCALE;
      pcnt     <= 16'd0;
      o_ack    <= 1'b0;
      o_dat    <= 16'd0;
    end else begin
      o_ack <= accept;

      if (accept && !i_we) begin
        unique case (sel)
          REG_CTRL:     o_dat <= ctrl_rd;
          REG_RELOAD:   o_dat <= reload;
          REG_COUNT:    o_dat <= count;
          REG_PRESCALE: o_dat <= prescale;
        endcase
      end

      // Prescaler: reload on enable rising, reload on tick, otherwise count down while enabled.
      if (ctrl_wr && i_dat[0] && !en)
        pcnt <= prescale;
      else if (tick)
        pcnt <= prescale;
      else if (en)
        pcnt <= pcnt - 16'd1;

      if (count_wr)
        count <= merge(count, i_dat, i_stb);
      else if (tick) begin
        if (count != 16'd0)
          count <= count - 16'd1;
        else if (auto_rl)
          count <= reload;
      end

      if (expire && !auto_rl)
        en <= 1'b0;

      if (ctrl_wr) begin
        en      <= i_dat[0];
        auto_rl <= i_dat[1];
        ie      <= i_dat[2];
      end

      // A new expiry beats a write-1-to-clear on the same edge.
      if (expire)
        pend <= 1'b1;
      else if (ctrl_wr && i_dat[3])
        pend <= 1'b0;

      if (wr && (sel == REG_RELOAD))
        reload <= merge(reload, i_dat, i_stb);
      if (wr && (sel == REG_PRESCALE))
        prescale <= merge(prescale, i_dat, i_stb);
    end
  end

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer: stimulus queues expected read data, a negedge
// monitor pops and compares on every ack; interrupt timing is checked inline.
module tb_bus_timer;

  localparam logic [15:0] RST_RELOAD   = 16'h0055;
  localparam logic [15:0] RST_PRESCALE = 16'h0003;

  localparam logic [1:0] A_CTRL = 2'd0, A_RELOAD = 2'd1, A_COUNT = 2'd2, A_PRESCALE = 2'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  addr = 2'd0;
  logic [15:0] wdat = 16'd0;
  logic [15:0] rdat;
  logic        we = 1'b0;
  logic        cyc = 1'b0;
  logic [1:0]  stb = 2'b00;
  logic        ack;
  logic        irq;

  bus_timer #(
    .RST_RELOAD  (RST_RELOAD),
    .RST_PRESCALE(RST_PRESCALE)
  ) dut (
    .i_clk  (clk),
    .i_reset(reset),
    .i_addr (addr),
    .i_dat  (wdat),
    .o_dat  (rdat),
    .i_we   (we),
    .i_cyc  (cyc),
    .i_stb  (stb),
    .o_ack  (ack),
    .o_int  (irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        chk;
    logic [15:0] exp;
    logic [7:0]  id;
  } sb_t;

  sb_t        sb[$];
  sb_t        mon_e;
  int         n_checks = 0;
  int         n_fails  = 0;
  logic [7:0] next_id  = 8'd0;
  logic [3:0] pat;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called and returns at 1ns after a rising edge.
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One access: accepted on the next edge, ack during the following cycle, returns after ack falls.
  task automatic xfer(input logic w, input logic [1:0] a, input logic [15:0] d,
                      input logic [1:0] s, input logic [15:0] exp);
    sb.push_back('{chk: !w, exp: exp, id: next_id});
    next_id++;
    we = w; addr = a; wdat = d; stb = s; cyc = 1'b1;
    @(posedge clk); #1;
    cyc = 1'b0; we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    xfer(1'b1, a, d, 2'b11, 16'd0);
  endtask

  // Strobes left at 00 on reads: the full word must come back regardless.
  task automatic rd(input logic [1:0] a, input logic [15:0] exp);
    xfer(1'b0, a, 16'hDEAD, 2'b00, exp);
  endtask

  always @(negedge clk) begin
    if (ack) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL unexpected_ack: got ack=1 expected no ack at %0t", $time);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.chk)
          check($sformatf("read_%0d", mon_e.id), rdat, mon_e.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset held two cycles.
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_ack", 16'(ack), 16'd0);
    check("reset_int", 16'(irq), 16'd0);
    rd(A_CTRL, 16'h0000);
    rd(A_COUNT, 16'h0000);
    rd(A_PRESCALE, RST_PRESCALE);
    rd(A_RELOAD, RST_RELOAD);

    // Handshake with cyc held for four cycles: two acks, alternating.
    sb.push_back('{chk: 1'b0, exp: 16'd0, id: next_id}); next_id++;
    sb.push_back('{chk: 1'b0, exp: 16'd0, id: next_id}); next_id++;
    we = 1'b1; addr = A_RELOAD; wdat = 16'h1234; stb = 2'b11; cyc = 1'b1;
    pat = 4'd0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      pat = {pat[2:0], ack};
    end
    cyc = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    check("ack_pattern", 16'(pat), 16'h000A);
    rd(A_RELOAD, 16'h1234);
    xfer(1'b1, A_RELOAD, 16'hABCD, 2'b01, 16'd0);
    rd(A_RELOAD, 16'h12CD);
    xfer(1'b1, A_RELOAD, 16'hFFFF, 2'b00, 16'd0);
    rd(A_RELOAD, 16'h12CD);

    // One-shot: expiry 4 cycles after the CTRL accept edge.
    wr(A_PRESCALE, 16'h0000);
    wr(A_COUNT, 16'h0003);
    wr(A_CTRL, 16'h0005);
    cycles(2);
    check("oneshot_int_early", 16'(irq), 16'd0);
    cycles(1);
    check("oneshot_int_rise", 16'(irq), 16'd1);
    rd(A_CTRL, 16'h000C);
    rd(A_COUNT, 16'h0000);
    wr(A_CTRL, 16'h0008);
    check("oneshot_int_clear", 16'(irq), 16'd0);
    rd(A_CTRL, 16'h0000);

    // Auto-reload, PRESCALE=1, RELOAD=2: expiry every 6 cycles.
    wr(A_PRESCALE, 16'h0001);
    wr(A_RELOAD, 16'h0002);
    wr(A_COUNT, 16'h0002);
    wr(A_CTRL, 16'h0007);
    cycles(4);
    check("auto_int_early", 16'(irq), 16'd0);
    cycles(1);
    check("auto_int_rise1", 16'(irq), 16'd1);
    wr(A_CTRL, 16'h000F);
    check("auto_int_cleared", 16'(irq), 16'd0);
    cycles(3);
    check("auto_int_low", 16'(irq), 16'd0);
    cycles(1);
    check("auto_int_rise2", 16'(irq), 16'd1);
    rd(A_CTRL, 16'h000F);
    wr(A_CTRL, 16'h0008);
    rd(A_CTRL, 16'h0000);

    // COUNT write on an expiry tick: written value wins, no PEND.
    wr(A_PRESCALE, 16'h0000);
    wr(A_COUNT, 16'h0001);
    wr(A_CTRL, 16'h0003);
    wr(A_COUNT, 16'h0100);
    rd(A_COUNT, 16'h00FF);
    rd(A_CTRL, 16'h0003);
    wr(A_CTRL, 16'h0008);

    // PEND clear on expiry edge keeps PEND; EN clear on a tick edge still ticks.
    wr(A_RELOAD, 16'h0010);
    wr(A_COUNT, 16'h0001);
    wr(A_CTRL, 16'h0003);
    wr(A_CTRL, 16'h000B);
    rd(A_CTRL, 16'h000B);
    wr(A_CTRL, 16'h0008);
    rd(A_COUNT, 16'h000C);
    rd(A_CTRL, 16'h0000);

    // Reset on the accept edge of a COUNT write: no ack, nothing lands.
    wr(A_COUNT, 16'h0042);
    reset = 1'b1; cyc = 1'b1; we = 1'b1; addr = A_COUNT; wdat = 16'h00FF; stb = 2'b11;
    @(posedge clk); #1;
    reset = 1'b0; cyc = 1'b0; we = 1'b0;
    check("reset_mid_ack", 16'(ack), 16'd0);
    @(posedge clk); #1;
    rd(A_COUNT, 16'h0000);
    rd(A_PRESCALE, RST_PRESCALE);
    rd(A_CTRL, 16'h0000);

    cycles(2);
    check("sb_drain", 16'(sb.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
